// File: rtl/data_memory_arbiter.sv
// Two-port arbiter and access sequencer for the MEM-stage data memory.
// Port P (pipeline) wins contested grants until a bounded streak forces port D (debug) through.
module data_memory_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ACCESS_LATENCY = 2,
  parameter int unsigned MAX_PIPE_WINS  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // Pipeline port
  input  logic                  pipe_req_i,
  input  logic                  pipe_we_i,
  input  logic [ADDR_WIDTH-1:0] pipe_addr_i,
  input  logic [DATA_WIDTH-1:0] pipe_wdata_i,
  output logic [DATA_WIDTH-1:0] pipe_rdata_o,
  output logic                  pipe_done_o,
  output logic                  pipe_stall_o,
  // Debug / loader port
  input  logic                  dbg_req_i,
  input  logic                  dbg_we_i,
  input  logic [ADDR_WIDTH-1:0] dbg_addr_i,
  input  logic [DATA_WIDTH-1:0] dbg_wdata_i,
  output logic [DATA_WIDTH-1:0] dbg_rdata_o,
  output logic                  dbg_done_o,
  // Memory side
  output logic                  mem_read_en_o,
  output logic                  mem_write_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int unsigned CntW = 4;
  localparam logic [CntW-1:0] LatInit = CntW'(ACCESS_LATENCY - 1);
  localparam logic [CntW-1:0] MaxWins = CntW'(MAX_PIPE_WINS);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;  // 1: debug port owns the access
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [CntW-1:0]       wins_q, wins_d;
  logic [DATA_WIDTH-1:0] pipe_rdata_q, pipe_rdata_d;
  logic [DATA_WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;
  logic                  grant_dbg;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      wins_q       <= '0;
      pipe_rdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      wins_q       <= wins_d;
      pipe_rdata_q <= pipe_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  assign grant_dbg = dbg_req_i & (~pipe_req_i | (wins_q == MaxWins));

  // Next-state and datapath
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    wins_d       = wins_q;
    pipe_rdata_d = pipe_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    case (state_q)
      StIdle: begin
        if (!dbg_req_i) begin
          wins_d = '0;
        end
        if (pipe_req_i || dbg_req_i) begin
          state_d = StBusy;
          owner_d = grant_dbg;
          we_d    = grant_dbg ? dbg_we_i    : pipe_we_i;
          addr_d  = grant_dbg ? dbg_addr_i  : pipe_addr_i;
          wdata_d = grant_dbg ? dbg_wdata_i : pipe_wdata_i;
          cnt_d   = LatInit;
          if (grant_dbg) begin
            wins_d = '0;
          end else if (dbg_req_i && (wins_q != MaxWins)) begin
            wins_d = wins_q + 1'b1;
          end
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          state_d = StDone;
          if (!we_q) begin
            if (owner_q) begin
              dbg_rdata_d = mem_rdata_i;
            end else begin
              pipe_rdata_d = mem_rdata_i;
            end
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs
  always_comb begin
    // A write is issued only on the last busy cycle so an abandoned access never writes
    mem_read_en_o  = (state_q == StBusy) & ~we_q;
    mem_write_en_o = (state_q == StBusy) & we_q & (cnt_q == '0);
    mem_addr_o     = addr_q;
    mem_wdata_o    = wdata_q;
    pipe_done_o    = (state_q == StDone) & ~owner_q;
    dbg_done_o     = (state_q == StDone) & owner_q;
    pipe_rdata_o   = pipe_rdata_q;
    dbg_rdata_o    = dbg_rdata_q;
    pipe_stall_o   = pipe_req_i & ~pipe_done_o;
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Randomized bench for data_memory_arbiter against a transaction-timing reference model.
module tb_data_memory_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LAT   = 2;
  localparam int MAXW  = 4;
  localparam int Words = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pipe_req, pipe_we, pipe_done, pipe_stall;
  logic [AW-1:0] pipe_addr;
  logic [DW-1:0] pipe_wdata, pipe_rdata;
  logic          dbg_req, dbg_we, dbg_done;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic          mem_read_en, mem_write_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] mem [Words];
  logic          mem_load;
  int            n_writes;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model state
  logic [DW-1:0] ref_mem [Words];
  bit            m_active, m_owner, m_we, p_granted, d_granted;
  int            m_g, m_wins, m_writes;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, exp_prd, exp_drd;
  int unsigned   p_req_pct, p_keep_pct, d_req_pct, d_keep_pct, d_abort_pct;

  always #5 clk = ~clk;

  data_memory_arbiter #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .ACCESS_LATENCY(LAT),
    .MAX_PIPE_WINS (MAXW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .pipe_req_i    (pipe_req),
    .pipe_we_i     (pipe_we),
    .pipe_addr_i   (pipe_addr),
    .pipe_wdata_i  (pipe_wdata),
    .pipe_rdata_o  (pipe_rdata),
    .pipe_done_o   (pipe_done),
    .pipe_stall_o  (pipe_stall),
    .dbg_req_i     (dbg_req),
    .dbg_we_i      (dbg_we),
    .dbg_addr_i    (dbg_addr),
    .dbg_wdata_i   (dbg_wdata),
    .dbg_rdata_o   (dbg_rdata),
    .dbg_done_o    (dbg_done),
    .mem_read_en_o (mem_read_en),
    .mem_write_en_o(mem_write_en),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_rdata_i   (mem_rdata)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    return (DW'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
  endfunction

  // Environment memory: poison data outside read enables catches mistimed captures
  assign mem_rdata = mem_read_en ? mem[mem_addr[7:2]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < Words; i++) mem[i] <= init_val(i);
      n_writes <= 0;
    end else if (mem_write_en) begin
      mem[mem_addr[7:2]] <= mem_wdata;
      n_writes <= n_writes + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_quiet(input string pfx);
    check_eq({pfx, "_pipe_rdata"}, pipe_rdata, '0);
    check_eq({pfx, "_dbg_rdata"}, dbg_rdata, '0);
    check_eq({pfx, "_pipe_done"}, 32'(pipe_done), '0);
    check_eq({pfx, "_dbg_done"}, 32'(dbg_done), '0);
    check_eq({pfx, "_read_en"}, 32'(mem_read_en), '0);
    check_eq({pfx, "_write_en"}, 32'(mem_write_en), '0);
    check_eq({pfx, "_mem_addr"}, mem_addr, '0);
    check_eq({pfx, "_mem_wdata"}, mem_wdata, '0);
  endtask

  task automatic rand_fields(output logic we, output logic [AW-1:0] addr,
                             output logic [DW-1:0] wd);
    we   = 1'($urandom_range(0, 1));
    addr = AW'($urandom_range(0, Words - 1)) << 2;
    wd   = $urandom();
  endtask

  // One clock of stimulus, model evaluation and checking, done at the falling edge
  task automatic step();
    bit busy, done, p_dn, d_dn, was_idle, gd;
    @(negedge clk);
    cyc++;
    busy = m_active && cyc > m_g && cyc <= m_g + LAT;
    done = m_active && cyc == m_g + LAT + 1;
    p_dn = done && !m_owner;
    d_dn = done && m_owner;
    if (done && !m_we) begin
      if (m_owner) exp_drd = ref_mem[m_addr[7:2]];
      else         exp_prd = ref_mem[m_addr[7:2]];
    end
    if (done && m_we) begin
      ref_mem[m_addr[7:2]] = m_wdata;
      m_writes++;
    end
    check_eq("mem_read_en", 32'(mem_read_en), 32'(busy && !m_we));
    check_eq("mem_write_en", 32'(mem_write_en), 32'(busy && m_we && cyc == m_g + LAT));
    check_eq("pipe_done", 32'(pipe_done), 32'(p_dn));
    check_eq("dbg_done", 32'(dbg_done), 32'(d_dn));
    check_eq("pipe_stall", 32'(pipe_stall), 32'(pipe_req && !p_dn));
    if (busy) begin
      check_eq("mem_addr", mem_addr, m_addr);
      if (m_we) check_eq("mem_wdata", mem_wdata, m_wdata);
    end
    check_eq("pipe_rdata", pipe_rdata, exp_prd);
    check_eq("dbg_rdata", dbg_rdata, exp_drd);

    was_idle = !m_active;
    if (done) begin
      m_active  = 1'b0;
      p_granted = 1'b0;
      d_granted = 1'b0;
    end

    // Pipeline requester
    if (p_dn) begin
      if ($urandom_range(0, 99) < p_keep_pct) rand_fields(pipe_we, pipe_addr, pipe_wdata);
      else pipe_req = 1'b0;
    end else if (!pipe_req) begin
      if ($urandom_range(0, 99) < p_req_pct) begin
        pipe_req = 1'b1;
        rand_fields(pipe_we, pipe_addr, pipe_wdata);
      end
    end else if (p_granted) begin
      rand_fields(pipe_we, pipe_addr, pipe_wdata);
    end

    // Debug requester; may withdraw while still waiting for a grant
    if (d_dn) begin
      if ($urandom_range(0, 99) < d_keep_pct) rand_fields(dbg_we, dbg_addr, dbg_wdata);
      else dbg_req = 1'b0;
    end else if (!dbg_req) begin
      if ($urandom_range(0, 99) < d_req_pct) begin
        dbg_req = 1'b1;
        rand_fields(dbg_we, dbg_addr, dbg_wdata);
      end
    end else if (d_granted) begin
      rand_fields(dbg_we, dbg_addr, dbg_wdata);
    end else if ($urandom_range(0, 99) < d_abort_pct) begin
      dbg_req = 1'b0;
    end

    // Arbitration happens only in idle cycles, on the values just driven
    if (was_idle) begin
      if (!dbg_req) m_wins = 0;
      if (pipe_req || dbg_req) begin
        gd       = dbg_req && (!pipe_req || m_wins == MAXW);
        m_active = 1'b1;
        m_g      = cyc;
        m_owner  = gd;
        if (gd) begin
          m_we      = dbg_we;
          m_addr    = dbg_addr;
          m_wdata   = dbg_wdata;
          m_wins    = 0;
          d_granted = 1'b1;
        end else begin
          m_we      = pipe_we;
          m_addr    = pipe_addr;
          m_wdata   = pipe_wdata;
          p_granted = 1'b1;
          if (dbg_req && m_wins < MAXW) m_wins++;
        end
      end
    end
  endtask

  task automatic run_phase(input int unsigned prq, input int unsigned pkp,
                           input int unsigned drq, input int unsigned dkp,
                           input int unsigned dab, input int n);
    p_req_pct   = prq;
    p_keep_pct  = pkp;
    d_req_pct   = drq;
    d_keep_pct  = dkp;
    d_abort_pct = dab;
    repeat (n) step();
  endtask

  initial begin
    rst_n      = 1'b0;
    mem_load   = 1'b1;
    pipe_req   = 1'b0;
    pipe_we    = 1'b0;
    pipe_addr  = '0;
    pipe_wdata = '0;
    dbg_req    = 1'b0;
    dbg_we     = 1'b0;
    dbg_addr   = '0;
    dbg_wdata  = '0;
    for (int i = 0; i < Words; i++) ref_mem[i] = init_val(i);
    m_active  = 1'b0;
    p_granted = 1'b0;
    d_granted = 1'b0;
    m_wins    = 0;
    m_writes  = 0;
    exp_prd   = '0;
    exp_drd   = '0;

    repeat (2) @(negedge clk);
    mem_load = 1'b0;
    check_quiet("reset");
    rst_n = 1'b1;

    // Debug write to 0x40 abandoned by reset during its first busy cycle
    dbg_req   = 1'b1;
    dbg_we    = 1'b1;
    dbg_addr  = 32'h40;
    dbg_wdata = 32'h0000_0055;
    @(negedge clk);
    check_eq("abort_busy_addr", mem_addr, 32'h40);
    rst_n = 1'b0;
    #1;
    check_quiet("abort");
    dbg_req   = 1'b0;
    dbg_we    = 1'b0;
    dbg_addr  = '0;
    dbg_wdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_quiet("post_abort");
    check_eq("abort_no_write", 32'(n_writes), 0);
    check_eq("abort_mem_0x40", mem[16], init_val(16));

    // Both ports hold requests: streaks of MAXW pipeline grants then one debug grant
    run_phase(100, 100, 100, 100, 0, 80);
    run_phase(40, 40, 30, 30, 0, 1500);
    run_phase(60, 90, 50, 20, 25, 1200);
    run_phase(0, 0, 0, 0, 100, 12);

    check_eq("write_count", 32'(n_writes), 32'(m_writes));
    for (int i = 0; i < Words; i++) check_eq("final_mem", mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
- Sequencing controller and two-port arbiter in front of the data memory used by the MIPS memory stage.
- Shares that memory between the pipeline MEM stage (port P) and a debug/loader port (port D). Each accepted access occupies the memory for ACCESS_LATENCY cycles.
- Stalls the pipeline until its access completes and returns read data through registered outputs.

Parameters:
ADDR_WIDTH, 32, byte address width passed through to memory
DATA_WIDTH, 32, data word width
ACCESS_LATENCY, 2, memory busy cycles per access (legal range 1..15)
MAX_PIPE_WINS, 4, consecutive contested P grants allowed before D is forced (legal range 1..15)

Ports:
clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
pipe_req  in  1  P access request, level, held until pipe_done
pipe_we  in  1  P write (1) / read (0)
pipe_addr  in  ADDR_WIDTH  P address (ALU result)
pipe_wdata  in  DATA_WIDTH  P store value
pipe_rdata  out  DATA_WIDTH  P load data, registered
pipe_done  out  1  one-cycle P completion pulse
pipe_stall  out  1  combinational: pipe_req & ~pipe_done
dbg_req  in  1  D request, level, held until dbg_done
dbg_we  in  1  D write/read
dbg_addr  in  ADDR_WIDTH  D address
dbg_wdata  in  DATA_WIDTH  D write data
dbg_rdata  out  DATA_WIDTH  D read data, registered
dbg_done  out  1  one-cycle D completion pulse
mem_read_en  out  1  memory read enable
mem_write_en  out  1  memory write enable
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data, valid while mem_read_en is high

Behaviour:
- Reset (Reset=0, async):
  - State goes to IDLE; latched owner, address, data and we are cleared.
  - Latency counter and win counter are cleared.
  - All outputs are 0: pipe_rdata, dbg_rdata, done pulses, mem enables, mem_addr, mem_wdata.
  - An access in flight is abandoned. No done pulse follows, and a pending write that had not reached its final BUSY cycle is never issued.
- FSM with three states: IDLE, BUSY, DONE.
- IDLE:
  - If no request is present, stay in IDLE.
  - Otherwise arbitrate, latch owner/we/addr/wdata, load the latency counter with ACCESS_LATENCY-1 and go to BUSY.
  - No memory enables are asserted in IDLE.
- Arbitration (IDLE only):
  - Only P requests: grant P. Only D requests: grant D.
  - Both request: grant P unless win_cnt==MAX_PIPE_WINS, in which case grant D.
- win_cnt update:
  - Increment (saturating) when P is granted while dbg_req=1.
  - Clear when D is granted, or in any IDLE cycle where dbg_req=0.
- BUSY:
  - mem_addr and mem_wdata come from the latched registers.
  - For a read, mem_read_en=1 in every BUSY cycle.
  - For a write, mem_write_en=1 only in the final BUSY cycle (counter==0), giving exactly one write per access.
  - The counter decrements each cycle. On counter==0 go to DONE; for a read, capture mem_rdata into the owner's rdata register on that edge.
- DONE (exactly 1 cycle):
  - The owner's done pulse is 1; enables are 0; next state is IDLE.
  - No grant is made in DONE, so a requester that keeps req high is re-granted no earlier than the following IDLE cycle.
- Timing:
  - Request seen in IDLE at cycle T.
  - BUSY occupies T+1..T+ACCESS_LATENCY.
  - done is high at T+ACCESS_LATENCY+1.
  - Minimum back-to-back spacing is ACCESS_LATENCY+2 cycles.
- rdata registers hold their value until the next completed read by the same owner. Writes do not modify rdata.
- Input changes after grant have no effect on the access in flight.
- pipe_stall is 1 while P waits for grant and throughout P's BUSY cycles, including while D owns the memory.
- Non-owner done is always 0. pipe_done and dbg_done are never high together.

Test Plan:
- Reset values: Reset=0 mid-BUSY for a D write to 0x40 -> all outputs 0 immediately; no mem_write_en ever issued; memory word at 0x40 unchanged.
- P write then read, ACCESS_LATENCY=2:
  - Write 0x000000AA to addr 0x10 -> mem_write_en high for exactly 1 cycle; pipe_done at T+3; pipe_stall high T..T+2.
  - Then read 0x10 -> pipe_rdata=0x000000AA at the pipe_done cycle.
- D-only read of 0x20 holding 0x12345678 -> dbg_done at T+3, dbg_rdata=0x12345678; pipe_stall stays 0.
- Simultaneous requests, P held high continuously, dbg_req held high, MAX_PIPE_WINS=4 -> grant sequence P,P,P,P,D,P,P,P,P,D...
- dbg_req drops between contested grants -> win_cnt cleared; 4 further contested P grants required before D is forced.
- ACCESS_LATENCY=1, back-to-back P reads of addrs 0x4 then 0x8 -> done pulses exactly 3 cycles apart; correct data on each; no read while in DONE.
